cycle_top: RTL and testbench
============================

// Module: cycle_top
// PURPOSE
//   Registered multi-function datapath. Slices a 261-bit packed input bus into four 64-bit
//   operands plus a 5-bit control field, and returns a 330-bit packed result bus.
//   Provides combinational results (sum, xor, rotate, popcount, compare) and stateful
//   results (accumulator, running max, sticky overflow). All results are registered once.
//   Top-level compute block; inputs are driven away from the active clock edge.
// PARAMETERS
//   none (all widths fixed: IN_W=261, OUT_W=330, operand width 64)
// PORTS
//   clk       input   1    clock; all state updates on rising edge
//   rst_n     input   1    synchronous, active-high reset (reset when 1, sampled on clk rise)
//   in_flat   input   261  packed operands/control (field map below)
//   out_flat  output  330  packed registered results (field map below)
// BEHAVIOUR
//   Input map:  A=in_flat[63:0]  B=[127:64]  C=[191:128]  D=[255:192]  OP=[260:256]
//   Output map (all fields registered; each updates on every rising edge unless reset):
//     [64:0]    SUM  = {1'b0,A} + {1'b0,B}, 65-bit unsigned, carry in bit 64
//     [128:65]  XOR  = A ^ C
//     [192:129] ACC  : OP[1]=1 -> 0 (clear has priority); else OP[0]=1 -> ACC+D mod 2^64;
//                      else hold
//     [256:193] MAX  : OP[2]=1 -> C (reload); else C>ACC... no: C>MAX (unsigned) -> C;
//                      else hold
//     [320:257] ROT  = B rotated left by OP[4:0] (0..31 bit positions); OP=0 -> B unchanged
//     [327:321] PCNT = popcount(D), 0..64, 7-bit
//     [328]     OVF  : sticky; set when an ACC add carries out of bit 63; cleared by OP[1]
//                      clear; a set and clear in the same cycle -> clear wins
//     [329]     EQ   = (A == C)
//   Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on out_flat after
//     edge N. No handshake; every cycle is a valid transaction.
//   Reset: while rst_n=1 at a rising edge, all out_flat bits, ACC, MAX and OVF become 0.
//     This includes reset asserted mid-stream: state is discarded and the inputs of that
//     cycle are ignored. The first post-reset edge computes from the current inputs,
//     with ACC=0 and MAX=0.
//   Arithmetic: all compares and adds unsigned; ACC wraps modulo 2^64.
//     MAX compares against its own registered value, not against the output bus.
//   Stateful fields (ACC, MAX, OVF) read their own registered state. The stateless fields
//     depend only on the current in_flat.
//   No X propagation from unused bits: every out_flat bit is driven by a register.
// TESTING
//   1. rst_n=1 for 2 edges, in_flat random -> out_flat==0. Release: next edge, fields
//      follow the input map.
//   2. A=64'hFFFF_FFFF_FFFF_FFFF, B=1 -> SUM=65'h1_0000_0000_0000_0000.
//      Same cycle, C=A -> EQ=1 and XOR=0.
//   3. OP=5'b00001, D=64'h8000_0000_0000_0000 for 2 cycles -> ACC=8000.., then ACC=0 with
//      OVF=1. Next, OP=5'b00011 -> ACC=0 and OVF=0.
//   4. C sequence 5, 3, 9 with OP[2]=0 -> MAX=5, 5, 9. Then C=2 with OP[2]=1 -> MAX=2.
//   5. B=64'h1, OP=5'd31 (OP[0..2] still decode) -> ROT=64'h8000_0000.
//      D=64'hFF -> PCNT=8.
//   6. Assert rst_n for 1 cycle mid-accumulation (ACC nonzero, OVF=1) -> all zero.
//      Next edge: ACC=D when OP[0]=1.

Source files
------------

// File: rtl/cycle_top.sv
// ---------------------------------------------------------------------------
// cycle_top
//   Registered multi-function datapath. Four 64-bit operands and a 5-bit
//   control field are unpacked from in_flat. Stateless results (sum, xor,
//   rotate, popcount, equality) and stateful results (accumulator, running
//   max, sticky overflow) are registered once and packed onto out_flat.
//   Latency is exactly one clock; every cycle is a transaction.
//
// Ports
//   clk       in   1    clock, all state on rising edge
//   rst_n     in   1    synchronous reset, ACTIVE HIGH (the name is historical)
//   in_flat   in   261  A=[63:0] B=[127:64] C=[191:128] D=[255:192] OP=[260:256]
//   out_flat  out  330  SUM=[64:0] XOR=[128:65] ACC=[192:129] MAX=[256:193]
//                       ROT=[320:257] PCNT=[327:321] OVF=[328] EQ=[329]
//
// OP decode (fields overlap on purpose):
//   OP[0]   accumulate D into ACC
//   OP[1]   clear ACC and OVF (wins over OP[0])
//   OP[2]   reload MAX from C
//   OP[4:0] rotate-left amount for ROT
// ---------------------------------------------------------------------------
module cycle_top (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [260:0] in_flat,
    output logic [329:0] out_flat
);

    // Operand unpacking
    logic [63:0]  w_a, w_b, w_c, w_d;
    logic [4:0]   w_op;

    assign w_a  = in_flat[63:0];
    assign w_b  = in_flat[127:64];
    assign w_c  = in_flat[191:128];
    assign w_d  = in_flat[255:192];
    assign w_op = in_flat[260:256];

    // Result registers
    logic [64:0]  r_sum;
    logic [63:0]  r_xor;
    logic [63:0]  r_acc;
    logic [63:0]  r_max;
    logic [63:0]  r_rot;
    logic [6:0]   r_pcnt;
    logic         r_ovf;
    logic         r_eq;

    // Combinational next values
    logic [64:0]  w_sum;
    logic [64:0]  w_acc_add;
    logic [127:0] w_rot_dbl;
    logic [63:0]  w_rot;
    logic [6:0]   w_pcnt;

    assign w_sum     = {1'b0, w_a} + {1'b0, w_b};
    assign w_acc_add = {1'b0, r_acc} + {1'b0, w_d};

    // Rotate by shifting a doubled copy; the upper half holds the wrapped
    // bits, so an amount of 0 falls out naturally as B unchanged.
    assign w_rot_dbl = {w_b, w_b} << w_op;
    assign w_rot     = w_rot_dbl[127:64];

    always_comb begin
        w_pcnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            w_pcnt = w_pcnt + {6'd0, w_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sum  <= '0;
            r_xor  <= '0;
            r_acc  <= '0;
            r_max  <= '0;
            r_rot  <= '0;
            r_pcnt <= '0;
            r_ovf  <= 1'b0;
            r_eq   <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_xor  <= w_a ^ w_c;
            r_rot  <= w_rot;
            r_pcnt <= w_pcnt;
            r_eq   <= (w_a == w_c);

            // Clear beats accumulate, and also beats an overflow raised by
            // an add in the same cycle.
            if (w_op[1]) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (w_op[0]) begin
                r_acc <= w_acc_add[63:0];
                if (w_acc_add[64]) r_ovf <= 1'b1;
            end

            // Running max compares against its own register, unsigned.
            if (w_op[2]) begin
                r_max <= w_c;
            end else if (w_c > r_max) begin
                r_max <= w_c;
            end
        end
    end

    assign out_flat = {r_eq, r_ovf, r_pcnt, r_rot, r_max, r_acc, r_xor, r_sum};

endmodule

// File: tb/tb_cycle_top.sv
module tb_cycle_top;

  logic         clk;
  logic         rst_n;
  logic [260:0] in_flat;
  logic [329:0] out_flat;

  int checks = 0;
  int errors = 0;

  logic [63:0] a, b, c, d;
  logic [4:0]  op;

  cycle_top u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flat  (in_flat),
    .out_flat (out_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [329:0] obs, input logic [329:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // drive fields, then advance one edge and settle
  task automatic step();
    in_flat = {op, d, c, b, a};
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] f_sum();  return out_flat[64:0];    endfunction
  function automatic logic [63:0] f_xor();  return out_flat[128:65];  endfunction
  function automatic logic [63:0] f_acc();  return out_flat[192:129]; endfunction
  function automatic logic [63:0] f_max();  return out_flat[256:193]; endfunction
  function automatic logic [63:0] f_rot();  return out_flat[320:257]; endfunction
  function automatic logic [6:0]  f_pcnt(); return out_flat[327:321]; endfunction
  function automatic logic        f_ovf();  return out_flat[328];     endfunction
  function automatic logic        f_eq();   return out_flat[329];     endfunction

  initial begin
    rst_n = 1'b1;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    c = {$urandom, $urandom}; d = {$urandom, $urandom};
    op = 5'($urandom);
    #2;
    step();
    chk("rst_e1", out_flat, '0);
    a = {$urandom, $urandom}; op = 5'b00001;
    step();
    chk("rst_e2", out_flat, '0);

    // release: sum carry, eq, xor zero
    rst_n = 1'b0;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; c = a; d = 64'd0; op = 5'd0;
    step();
    chk("sum_carry", f_sum(), 65'h1_0000_0000_0000_0000);
    chk("eq_one",    f_eq(),  1'b1);
    chk("xor_zero",  f_xor(), 64'd0);
    chk("acc_post",  f_acc(), 64'd0);
    chk("max_post",  f_max(), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rot_zero",  f_rot(), 64'd1);
    chk("pcnt_zero", f_pcnt(), 7'd0);

    // accumulate with carry-out
    a = 64'd3; b = 64'd4; c = 64'd0; d = 64'h8000_0000_0000_0000; op = 5'b00001;
    step();
    chk("acc1",   f_acc(), 64'h8000_0000_0000_0000);
    chk("ovf1",   f_ovf(), 1'b0);
    chk("sum7",   f_sum(), 65'd7);
    chk("xor3",   f_xor(), 64'd3);
    chk("eq0",    f_eq(),  1'b0);
    chk("rot1",   f_rot(), 64'd8);
    chk("pcnt1",  f_pcnt(), 7'd1);
    step();
    chk("acc_wrap", f_acc(), 64'd0);
    chk("ovf_set",  f_ovf(), 1'b1);
    step();
    chk("acc_again", f_acc(), 64'h8000_0000_0000_0000);
    chk("ovf_stick", f_ovf(), 1'b1);
    // clear with a carrying add in the same cycle: clear wins
    op = 5'b00011;
    step();
    chk("acc_clr", f_acc(), 64'd0);
    chk("ovf_clr", f_ovf(), 1'b0);
    chk("rot3",    f_rot(), 64'd32);

    // running max
    op = 5'b00100; c = 64'd0;
    step();
    chk("max_rl0", f_max(), 64'd0);
    op = 5'd0;
    c = 64'd5; step(); chk("max5a", f_max(), 64'd5);
    c = 64'd3; step(); chk("max5b", f_max(), 64'd5);
    c = 64'd9; step(); chk("max9",  f_max(), 64'd9);
    chk("acc_hold", f_acc(), 64'd0);
    op = 5'b00100; c = 64'd2;
    step();
    chk("max_rl2", f_max(), 64'd2);
    op = 5'd0; c = 64'h8000_0000_0000_0001;
    step();
    chk("max_big", f_max(), 64'h8000_0000_0000_0001);

    // rotate by 31, popcount
    b = 64'd1; op = 5'd31; d = 64'hFF; c = 64'd7;
    step();
    chk("rot31",  f_rot(),  64'h8000_0000);
    chk("pcnt8",  f_pcnt(), 7'd8);
    chk("max_rl7", f_max(), 64'd7);
    chk("acc_op31", f_acc(), 64'd0);
    op = 5'd0; d = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h8000_0000_0000_0001;
    step();
    chk("pcnt64", f_pcnt(), 7'd64);
    chk("rot0",   f_rot(),  64'h8000_0000_0000_0001);

    // mid-stream reset
    op = 5'b00001; d = 64'h8000_0000_0000_0000;
    step(); step(); step();
    chk("acc_pre", f_acc(), 64'h8000_0000_0000_0000);
    chk("ovf_pre", f_ovf(), 1'b1);
    rst_n = 1'b1; d = 64'd5; c = 64'd9;
    step();
    chk("rst_mid", out_flat, '0);
    rst_n = 1'b0;
    step();
    chk("acc_d",   f_acc(), 64'd5);
    chk("ovf_0",   f_ovf(), 1'b0);
    chk("max_9",   f_max(), 64'd9);
    chk("pcnt_5",  f_pcnt(), 7'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
